// File: rtl/vm2002_pkg.sv
// vm2002_pkg: shared types and helpers for the vm2002 payment stage.
//   coin_t       - coin denominations as seen on the acceptor/dispenser ports
//   acc_state_t  - coin acceptor FSM states
//   acc_pulse_t  - bundle of the single-cycle handshake pulses
//   coin_value() - denomination value in nickel units (0 for COIN_NONE/undefined)
package vm2002_pkg;

    typedef enum logic [2:0] {
        COIN_NONE = 3'd0,
        NICKEL    = 3'd1,
        DIME      = 3'd2,
        QUARTER   = 3'd3,
        DOLLAR    = 3'd4
    } coin_t;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic ack;
        logic nak;
        logic reject;
    } acc_pulse_t;

    // Escrow ceiling: $10.00 in nickel units.
    localparam logic [15:0] MAX_CREDIT_DEFAULT = 16'd200;

    function automatic logic [15:0] coin_value(coin_t c);
        case (c)
            NICKEL:  return 16'd1;
            DIME:    return 16'd2;
            QUARTER: return 16'd5;
            DOLLAR:  return 16'd20;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm2002_change_picker.sv
// vm2002_change_picker: combinational greedy change selection.
//   credit in  [15:0] - remaining escrow credit, nickel units
//   coin   out coin_t - largest coin whose value fits in credit, COIN_NONE when credit is 0
module vm2002_change_picker
    import vm2002_pkg::*;
(
    input  logic [15:0] credit,
    output coin_t       coin
);

    always_comb begin
        if (credit >= coin_value(DOLLAR))       coin = DOLLAR;
        else if (credit >= coin_value(QUARTER)) coin = QUARTER;
        else if (credit >= coin_value(DIME))    coin = DIME;
        else if (credit >= coin_value(NICKEL))  coin = NICKEL;
        else                                    coin = COIN_NONE;
    end

endmodule

// File: rtl/vm2002_coin_acceptor.sv
// vm2002_coin_acceptor: escrow credit, purchase debits and coin-by-coin change/refund.
// Optional feature macro: VM_ESCROW_TIMEOUT_EN (auto-refund after TIMEOUT_CYCLES idle cycles).
// Ports:
//   clk, rst (async, active low)
//   coin_valid/coin           - inserted coin strobe and denomination
//   debit_req/debit_amt       - purchase debit strobe and price (nickel units)
//   refund_req                - coin-return strobe
//   change_ready              - dispenser accepts change_coin this cycle
//   credit                    - current escrow credit
//   debit_ack/debit_nak       - registered debit outcome pulses
//   coin_reject               - registered pulse: inserted coin returned
//   change_valid/change_coin  - change dispense request
//   busy                      - FSM not in IDLE
module vm2002_coin_acceptor
    import vm2002_pkg::*;
#(
    parameter logic [15:0] MAX_CREDIT     = MAX_CREDIT_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin_valid,
    input  coin_t       coin,
    input  logic        debit_req,
    input  logic [15:0] debit_amt,
    input  logic        refund_req,
    input  logic        change_ready,
    output logic [15:0] credit,
    output logic        debit_ack,
    output logic        debit_nak,
    output logic        coin_reject,
    output logic        change_valid,
    output coin_t       change_coin,
    output logic        busy
);

    acc_state_t  state_q, state_d;
    logic [15:0] credit_q, credit_d;
    acc_pulse_t  pulse_q, pulse_d;

    coin_t       pick_coin;
    logic [15:0] coin_val;
    logic [16:0] coin_sum;
    logic [15:0] debit_rem;

    vm2002_change_picker u_picker (
        .credit (credit_q),
        .coin   (pick_coin)
    );

    assign coin_val  = coin_value(coin);
    // 17-bit sum so an overflow past 16 bits can never look like a small credit.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign debit_rem = credit_q - debit_amt;

`ifdef VM_ESCROW_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            pulse_q  <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            pulse_q  <= pulse_d;
        end
    end

`ifdef VM_ESCROW_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt_q <= '0;
        else      tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        pulse_d  = '0;
        case (state_q)
            IDLE: begin
                // Only the highest-priority strobe may touch credit; losers are bounced.
                if (refund_req) begin
                    if (credit_q != '0) state_d = CHANGE;
                    pulse_d.nak    = debit_req;
                    pulse_d.reject = coin_valid;
                end else if (debit_req) begin
                    if (debit_amt <= credit_q) begin
                        pulse_d.ack = 1'b1;
                        credit_d    = debit_rem;
                        if (debit_rem != '0) state_d = CHANGE;
                    end else begin
                        pulse_d.nak = 1'b1;
                    end
                    pulse_d.reject = coin_valid;
                end else if (coin_valid) begin
                    if (coin_val != '0 && coin_sum <= {1'b0, MAX_CREDIT})
                        credit_d = coin_sum[15:0];
                    else
                        pulse_d.reject = 1'b1;
                end
            end
            CHANGE: begin
                pulse_d.nak    = debit_req;
                pulse_d.reject = coin_valid;
                // credit is nonzero throughout CHANGE, so pick_coin is a real coin here.
                if (change_ready) begin
                    credit_d = credit_q - coin_value(pick_coin);
                    if (credit_q == coin_value(pick_coin)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef VM_ESCROW_TIMEOUT_EN
        tmo_cnt_d = '0;
        if (state_q == IDLE && credit_q != '0 && !(coin_valid || debit_req || refund_req)) begin
            if (tmo_cnt_q == TMO_LAST) state_d = CHANGE;
            else                       tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
    end

    // Outputs: change port is derived from registered state/credit, so it holds while stalled.
    always_comb begin
        change_valid = (state_q == CHANGE);
        change_coin  = change_valid ? pick_coin : COIN_NONE;
        busy         = (state_q != IDLE);
        credit       = credit_q;
        debit_ack    = pulse_q.ack;
        debit_nak    = pulse_q.nak;
        coin_reject  = pulse_q.reject;
    end

endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// tb_vm2002_coin_acceptor: directed + randomized bench for vm2002_coin_acceptor,
// checked every cycle against a money-level reference model.
// Works in both builds (VM_ESCROW_TIMEOUT_EN defined or not).
module tb_vm2002_coin_acceptor;
    import vm2002_pkg::*;

    localparam int TB_TMO = 8;
    localparam int MAXC   = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid, debit_req, refund_req, change_ready;
    coin_t       coin_i;
    logic [15:0] debit_amt;
    logic [15:0] credit;
    logic        debit_ack, debit_nak, coin_reject, change_valid, busy;
    coin_t       change_coin;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_credit;
    bit m_change;
    bit e_ack, e_nak, e_rej;
    int m_idle;

    always #5 clk = ~clk;

    vm2002_coin_acceptor #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin         (coin_i),
        .debit_req    (debit_req),
        .debit_amt    (debit_amt),
        .refund_req   (refund_req),
        .change_ready (change_ready),
        .credit       (credit),
        .debit_ack    (debit_ack),
        .debit_nak    (debit_nak),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .busy         (busy)
    );

    function automatic int denom(coin_t c);
        case (c)
            NICKEL:  return 1;
            DIME:    return 2;
            QUARTER: return 5;
            DOLLAR:  return 20;
            default: return 0;
        endcase
    endfunction

    function automatic coin_t greedy(int c);
        coin_t ord[4] = '{DOLLAR, QUARTER, DIME, NICKEL};
        for (int i = 0; i < 4; i++)
            if (denom(ord[i]) <= c) return ord[i];
        return COIN_NONE;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_change = 0; m_idle = 0;
        e_ack = 0; e_nak = 0; e_rej = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit any_strobe;
        any_strobe = coin_valid || debit_req || refund_req;
        e_ack = 0; e_nak = 0; e_rej = 0;
        if (m_change) begin
            e_rej = coin_valid;
            e_nak = debit_req;
            if (change_ready) begin
                m_credit = m_credit - denom(greedy(m_credit));
                if (m_credit == 0) m_change = 0;
            end
            m_idle = 0;
        end else begin
            if (refund_req) begin
                if (m_credit > 0) m_change = 1;
                e_nak = debit_req;
                e_rej = coin_valid;
            end else if (debit_req) begin
                if (int'(debit_amt) <= m_credit) begin
                    e_ack = 1;
                    m_credit = m_credit - int'(debit_amt);
                    if (m_credit > 0) m_change = 1;
                end else begin
                    e_nak = 1;
                end
                e_rej = coin_valid;
            end else if (coin_valid) begin
                if (denom(coin_i) > 0 && m_credit + denom(coin_i) <= MAXC)
                    m_credit = m_credit + denom(coin_i);
                else
                    e_rej = 1;
            end
`ifdef VM_ESCROW_TIMEOUT_EN
            if (!any_strobe && m_credit > 0 && !m_change) begin
                m_idle++;
                if (m_idle == TB_TMO) begin
                    m_change = 1;
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
`else
            if (any_strobe) m_idle = 0;
`endif
        end
    endtask

    task automatic check_outputs();
        chk("credit",       32'(credit),       32'(m_credit));
        chk("debit_ack",    32'(debit_ack),    32'(e_ack));
        chk("debit_nak",    32'(debit_nak),    32'(e_nak));
        chk("coin_reject",  32'(coin_reject),  32'(e_rej));
        chk("change_valid", 32'(change_valid), 32'(m_change));
        chk("change_coin",  32'(change_coin),  32'(m_change ? greedy(m_credit) : COIN_NONE));
        chk("busy",         32'(busy),         32'(m_change));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        coin_valid = 0;
        debit_req  = 0;
        refund_req = 0;
    endtask

    task automatic insert(coin_t c);
        coin_valid = 1;
        coin_i     = c;
        step();
    endtask

    task automatic drain();
        change_ready = 1;
        for (int i = 0; i < 200 && m_change; i++) step();
        chk("drain_done", 32'(busy), 32'(0));
    endtask

    task automatic refund_all();
        refund_req = 1;
        step();
        drain();
    endtask

    initial begin
        rst = 0;
        coin_valid = 0; debit_req = 0; refund_req = 0; change_ready = 0;
        coin_i = COIN_NONE; debit_amt = '0;
        model_reset();
        #12;
        check_outputs();
        rst = 1;
        step();

        // 1: basic accumulation
        insert(QUARTER); chk("t1_q", 32'(credit), 32'(5));
        insert(DIME);    chk("t1_d", 32'(credit), 32'(7));
        insert(NICKEL);  chk("t1_n", 32'(credit), 32'(8));
        refund_all();

        // 2: ceiling
        repeat (9) insert(DOLLAR);
        repeat (3) insert(QUARTER);
        chk("t2_195", 32'(credit), 32'(195));
        insert(DOLLAR);
        chk("t2_rej", 32'(coin_reject), 32'(1));
        chk("t2_hold", 32'(credit), 32'(195));
        insert(QUARTER);
        chk("t2_200", 32'(credit), 32'(200));
        insert(NICKEL);
        chk("t2_full_rej", 32'(coin_reject), 32'(1));
        refund_all();

        // 3: purchase with change and a stalled dispenser
        insert(DOLLAR); insert(QUARTER); insert(QUARTER);
        change_ready = 0;
        debit_req = 1; debit_amt = 16'd25;
        step();
        chk("t3_ack", 32'(debit_ack), 32'(1));
        chk("t3_rem", 32'(credit), 32'(5));
        repeat (3) begin
            step();
            chk("t3_stall_coin", 32'(change_coin), 32'(QUARTER));
        end
        change_ready = 1;
        step();
        chk("t3_zero", 32'(credit), 32'(0));
        chk("t3_idle", 32'(change_valid), 32'(0));

        // 4: insufficient credit, then refund beats debit and coin in one cycle
        repeat (5) insert(DIME);
        change_ready = 0;
        debit_req = 1; debit_amt = 16'd12;
        step();
        chk("t4_nak", 32'(debit_nak), 32'(1));
        chk("t4_keep", 32'(credit), 32'(10));
        refund_req = 1; debit_req = 1; coin_valid = 1; coin_i = DIME;
        step();
        chk("t4_rej", 32'(coin_reject), 32'(1));
        chk("t4_busy", 32'(busy), 32'(1));
        drain();

        // 5: greedy sequence, then async reset mid-change
        insert(DOLLAR); insert(QUARTER); insert(DIME);
        change_ready = 0;
        refund_req = 1;
        step();
        chk("t5_dollar", 32'(change_coin), 32'(DOLLAR));
        change_ready = 1;
        step();
        chk("t5_quarter", 32'(change_coin), 32'(QUARTER));
        #2 rst = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst = 1;
        change_ready = 0;

        // 6: escrow timeout behaviour
        insert(DIME);
`ifdef VM_ESCROW_TIMEOUT_EN
        repeat (TB_TMO) step();
        chk("t6_tmo_busy", 32'(busy), 32'(1));
        chk("t6_tmo_coin", 32'(change_coin), 32'(DIME));
`else
        repeat (100) step();
        chk("t6_hold", 32'(credit), 32'(2));
        chk("t6_idle", 32'(busy), 32'(0));
`endif
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            coin_valid   = ($urandom_range(0, 99) < 45);
            coin_i       = coin_t'($urandom_range(0, 7));
            debit_req    = ($urandom_range(0, 99) < 10);
            debit_amt    = 16'($urandom_range(0, 40));
            refund_req   = ($urandom_range(0, 99) < 4);
            change_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
